// File: rtl/cube_pkg.sv
// Shared types and sizing helpers for the LED cube scan datapath.
package cube_pkg;

  localparam int NUM_ROWS   = 16;
  localparam int BIT_PLANES = 8;
  localparam int ROW_W      = $clog2(NUM_ROWS);
  localparam int PLANE_W    = $clog2(BIT_PLANES);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_FIRST,
    BLANK,
    LATCH,
    DISPLAY,
    WAIT_SHIFT
  } scan_state_t;

  // Wide enough to hold the longest plane dwell, BASE << (PLANES-1).
  function automatic int dwell_w(input int base, input int planes);
    return $clog2(base << (planes - 1)) + 1;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/row_scan_scheduler.sv
// BCM row/plane scan sequencer: requests shifts, drives latch, OE and row select.
// Handshake: shift_start / shift_done / swap_ack are single-cycle pulses; a pulse is consumed in the cycle it is high.
module row_scan_scheduler #(
  parameter int NUM_ROWS    = cube_pkg::NUM_ROWS,
  parameter int BIT_PLANES  = cube_pkg::BIT_PLANES,
  parameter int BASE_TICKS  = 8,
  parameter int BLANK_TICKS = 4,
  parameter int LATCH_TICKS = 2,
  localparam int ROW_BITS   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int PLANE_BITS = (BIT_PLANES > 1) ? $clog2(BIT_PLANES) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic                  shift_start,
  output logic [ROW_BITS-1:0]   shift_row,
  output logic [PLANE_BITS-1:0] shift_plane,
  input  logic                  shift_done,
  output logic                  latch_enable,
  output logic                  output_enable_n,
  output logic [NUM_ROWS-1:0]   row_select_n,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  frame_start,
  output cube_pkg::scan_state_t dbg_state
);

  import cube_pkg::*;

  localparam int DW = dwell_w(BASE_TICKS, BIT_PLANES);

  scan_state_t           state, state_nx;
  logic [ROW_BITS-1:0]   ptr_row, nxt_row;
  logic [PLANE_BITS-1:0] ptr_plane, nxt_plane, cur_plane;
  logic                  done_flag, pending;
  logic                  issue, load, t_done;
  logic [DW-1:0]         load_val;
  logic                  done_accept, done_now, enter_latch;

  // A done coinciding with our own shift_start belongs to nothing we track.
  assign done_accept = shift_done && !shift_start;
  assign done_now    = done_flag || done_accept;
  assign enter_latch = (state == BLANK) && t_done;
  assign dbg_state   = state;

  dwell_timer #(.W(DW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .done     (t_done)
  );

  // Successor of the pair being latched: plane first, then row, then wrap.
  always_comb begin
    nxt_row   = shift_row;
    nxt_plane = shift_plane + PLANE_BITS'(1);
    if (shift_plane == PLANE_BITS'(BIT_PLANES - 1)) begin
      nxt_plane = '0;
      nxt_row   = (shift_row == ROW_BITS'(NUM_ROWS - 1)) ? '0 : shift_row + ROW_BITS'(1);
    end
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    load     = 1'b0;
    load_val = '0;
    case (state)
      IDLE: begin
        if (enable) begin
          issue    = 1'b1;
          state_nx = SHIFT_FIRST;
        end
      end
      SHIFT_FIRST: begin
        if (done_now) begin
          state_nx = BLANK;
          load     = 1'b1;
          load_val = DW'(BLANK_TICKS - 1);
        end
      end
      BLANK: begin
        if (t_done) begin
          state_nx = LATCH;
          load     = 1'b1;
          load_val = DW'(LATCH_TICKS - 1);
        end
      end
      LATCH: begin
        if (t_done) begin
          state_nx = DISPLAY;
          load     = 1'b1;
          load_val = (DW'(BASE_TICKS) << cur_plane) - DW'(1);
          issue    = enable;
        end
      end
      DISPLAY: begin
        if (t_done) begin
          if (done_now && enable) begin
            state_nx = BLANK;
            load     = 1'b1;
            load_val = DW'(BLANK_TICKS - 1);
          end else if (pending && !done_accept) begin
            state_nx = WAIT_SHIFT;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      WAIT_SHIFT: begin
        if (done_now) begin
          if (enable) begin
            state_nx = BLANK;
            load     = 1'b1;
            load_val = DW'(BLANK_TICKS - 1);
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      ptr_row         <= '0;
      ptr_plane       <= '0;
      cur_plane       <= '0;
      done_flag       <= 1'b0;
      pending         <= 1'b0;
      shift_start     <= 1'b0;
      shift_row       <= '0;
      shift_plane     <= '0;
      swap_ack        <= 1'b0;
      latch_enable    <= 1'b0;
      output_enable_n <= 1'b1;
      row_select_n    <= '1;
      frame_start     <= 1'b0;
    end else begin
      state           <= state_nx;
      shift_start     <= issue;
      swap_ack        <= issue && swap_req && (ptr_row == '0) && (ptr_plane == '0);
      latch_enable    <= (state_nx == LATCH);
      output_enable_n <= (state_nx != DISPLAY);
      frame_start     <= enter_latch && (shift_row == '0) && (shift_plane == '0);

      if (issue) begin
        shift_row   <= ptr_row;
        shift_plane <= ptr_plane;
      end else if (state_nx == IDLE) begin
        shift_row   <= '0;
        shift_plane <= '0;
      end

      // The pointer moves on only once a pair is latched, so a shift that
      // completes just before going idle is requested again on re-enable.
      if (enter_latch) begin
        row_select_n <= ~(NUM_ROWS'(1) << shift_row);
        cur_plane    <= shift_plane;
        ptr_row      <= nxt_row;
        ptr_plane    <= nxt_plane;
      end else if (state_nx == IDLE) begin
        row_select_n <= '1;
      end

      if (issue || enter_latch) begin
        done_flag <= 1'b0;
      end else if (done_accept) begin
        done_flag <= 1'b1;
      end

      if (issue) begin
        pending <= 1'b1;
      end else if (done_accept) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_row_scan_scheduler.sv
// Scoreboard bench for row_scan_scheduler with a small 2-row, 2-plane configuration.
`timescale 1ns/1ps
module tb_row_scan_scheduler;
  import cube_pkg::*;

  localparam int ROWS   = 2;
  localparam int PLANES = 2;
  localparam int BASE   = 2;
  localparam int BLNK   = 1;
  localparam int LTCH   = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        shift_done = 1'b0;
  logic        swap_req = 1'b0;
  logic        shift_start, latch_enable, output_enable_n, swap_ack, frame_start;
  logic [0:0]  shift_row, shift_plane;
  logic [1:0]  row_select_n;
  scan_state_t dbg_state;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  row_scan_scheduler #(
    .NUM_ROWS    (ROWS),
    .BIT_PLANES  (PLANES),
    .BASE_TICKS  (BASE),
    .BLANK_TICKS (BLNK),
    .LATCH_TICKS (LTCH)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .shift_start     (shift_start),
    .shift_row       (shift_row),
    .shift_plane     (shift_plane),
    .shift_done      (shift_done),
    .latch_enable    (latch_enable),
    .output_enable_n (output_enable_n),
    .row_select_n    (row_select_n),
    .swap_req        (swap_req),
    .swap_ack        (swap_ack),
    .frame_start     (frame_start),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [2:0] exp_shift_q[$];   // {row, plane, swap_ack}
  logic [2:0] exp_latch_q[$];   // {row_select_n, frame_start}
  logic [7:0] exp_oe_q[$];      // OE-low run length in cycles

  int n_checks = 0;
  int n_pass = 0;
  int n_latch = 0;
  int wait_cycles = 0;
  int sh_delay = 3;
  int sh_cnt = 0;
  int oe_run = 0;
  logic prev_latch = 1'b0;
  logic busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic exp_shift(input logic r, input logic p, input logic ack);
    exp_shift_q.push_back({r, p, ack});
  endtask

  task automatic exp_latch(input logic [1:0] rs, input logic fs);
    exp_latch_q.push_back({rs, fs});
  endtask

  task automatic wait_latches(input int n);
    int budget = 400;
    while (n_latch < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (n_latch < n) begin
      n_checks++;
      $display("FAIL wait_latches: got %0d latches, expected %0d", n_latch, n);
    end
  endtask

  task automatic wait_oe_low();
    int budget = 50;
    do begin
      @(negedge clk);
      budget--;
    end while (output_enable_n && budget > 0);
    if (output_enable_n) begin
      n_checks++;
      $display("FAIL wait_oe_low: got output_enable_n=1, expected 0");
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_oe_n"}, output_enable_n, 1);
    check({tag, "_row_sel"}, row_select_n, 2'b11);
    check({tag, "_latch"}, latch_enable, 0);
    check({tag, "_shift_start"}, shift_start, 0);
    check({tag, "_swap_ack"}, swap_ack, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_shift_pair"}, {shift_row, shift_plane}, 0);
    check({tag, "_state"}, int'(dbg_state), int'(IDLE));
  endtask

  // ---------------- monitor + shifter model ----------------
  always @(negedge clk) begin
    logic [2:0] e3;
    logic [7:0] e8;
    if (!reset_n) begin
      prev_latch = 1'b0;
      oe_run = 0;
      busy = 1'b0;
    end else begin
      if (shift_start) begin
        if (exp_shift_q.size() == 0) fail_event("unexpected_shift");
        else begin
          e3 = exp_shift_q.pop_front();
          check("shift_pair_ack", {shift_row, shift_plane, swap_ack}, e3);
        end
        busy = 1'b1;
      end else if (swap_ack) begin
        fail_event("stray_swap_ack");
      end
      if (shift_done) busy = 1'b0;

      if (latch_enable && !prev_latch) begin
        n_latch++;
        check("latch_after_done", busy, 0);
        check("oe_off_at_latch", output_enable_n, 1);
        if (exp_latch_q.size() == 0) fail_event("unexpected_latch");
        else begin
          e3 = exp_latch_q.pop_front();
          check("latch_row_frame", {row_select_n, frame_start}, e3);
        end
      end else if (frame_start) begin
        fail_event("stray_frame_start");
      end
      prev_latch = latch_enable;

      if (dbg_state == WAIT_SHIFT) begin
        wait_cycles++;
        check("oe_off_in_wait", output_enable_n, 1);
      end

      if (!output_enable_n) oe_run++;
      else if (oe_run > 0) begin
        if (exp_oe_q.size() == 0) fail_event("unexpected_oe_run");
        else begin
          e8 = exp_oe_q.pop_front();
          check("oe_low_width", oe_run, e8);
        end
        oe_run = 0;
      end
    end

    // Shifter: shift_done pulses sh_delay cycles after shift_start.
    shift_done = 1'b0;
    if (!reset_n) sh_cnt = 0;
    else begin
      if (sh_cnt != 0) begin
        sh_cnt--;
        if (sh_cnt == 0) shift_done = 1'b1;
      end
      if (shift_start) sh_cnt = sh_delay;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Run 1: steady scan, swap pending, shift delay 3.
    swap_req = 1'b1;
    exp_shift(0, 0, 1); exp_shift(0, 1, 0); exp_shift(1, 0, 0); exp_shift(1, 1, 0);
    exp_shift(0, 0, 1); exp_shift(0, 1, 0); exp_shift(1, 0, 0);
    exp_latch(2'b10, 1); exp_latch(2'b10, 0); exp_latch(2'b01, 0); exp_latch(2'b01, 0);
    exp_latch(2'b10, 1); exp_latch(2'b10, 0);
    exp_oe_q.push_back(8'd2); exp_oe_q.push_back(8'd4); exp_oe_q.push_back(8'd2);
    exp_oe_q.push_back(8'd4); exp_oe_q.push_back(8'd2); exp_oe_q.push_back(8'd4);
    enable = 1'b1;
    @(negedge clk);
    check("enable_to_shift_latency", shift_start, 1);
    check("first_shift_pair", {shift_row, shift_plane}, 0);
    wait_latches(6);
    wait_oe_low();
    enable = 1'b0;
    repeat (12) @(negedge clk);
    check_idle_outputs("idle_after_drop");

    // Run 2: resume at stored pair, slow shifter forces WAIT_SHIFT, no swap.
    swap_req = 1'b0;
    sh_delay = 6;
    wait_cycles = 0;
    exp_shift(1, 0, 0); exp_shift(1, 1, 0); exp_shift(0, 0, 0);
    exp_latch(2'b01, 0); exp_latch(2'b01, 0);
    exp_oe_q.push_back(8'd2);
    enable = 1'b1;
    wait_latches(8);
    wait_oe_low();
    #1 reset_n = 1'b0;
    #2 check_idle_outputs("async_reset");
    check("wait_shift_cycles", wait_cycles, 5);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Run 3: pointer back at (0,0) after reset.
    swap_req = 1'b1;
    sh_delay = 3;
    exp_shift(0, 0, 1); exp_shift(0, 1, 0);
    exp_latch(2'b10, 1);
    exp_oe_q.push_back(8'd2);
    enable = 1'b1;
    wait_latches(9);
    wait_oe_low();
    enable = 1'b0;
    repeat (15) @(negedge clk);
    check_idle_outputs("final_idle");
    check("shift_q_drained", exp_shift_q.size(), 0);
    check("latch_q_drained", exp_latch_q.size(), 0);
    check("oe_q_drained", exp_oe_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/row_scan_scheduler.md
Name: row_scan_scheduler

Overview:
Sequences the LED cube's serial RGB datapath for binary-code-modulated (BCM) display. Walks rows × bit planes and requests a shift from the shifter for each (row, plane) pair. Drives latch_enable, output_enable_n and the active-low one-hot row_select_n with weighted dwell times. Shifting of the next plane overlaps display of the current one; a frame-boundary handshake lets the frame buffer swap cleanly.

Parameters:
NUM_ROWS, 16, rows scanned (row_select_n width)
BIT_PLANES, 8, BCM planes per row
BASE_TICKS, 8, clk cycles of OE-on for plane 0; plane p dwells BASE_TICKS<<p
BLANK_TICKS, 4, OE-off cycles before every latch (≥1)
LATCH_TICKS, 2, latch_enable high cycles (≥1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run scan when high
shift_start  out  1  one-cycle pulse: shifter begins loading shift_row/shift_plane
shift_row  out  clog2(NUM_ROWS)  row address of the requested shift, valid at shift_start
shift_plane  out  clog2(BIT_PLANES)  plane address of the requested shift
shift_done  in  1  one-cycle pulse from shifter: data shifted
latch_enable  out  1  transfers shift registers to driver outputs
output_enable_n  out  1  active-low driver enable
row_select_n  out  NUM_ROWS  active-low one-hot row drive
swap_req  in  1  frame buffer has a new frame pending
swap_ack  out  1  one-cycle pulse: swap buffers now
frame_start  out  1  one-cycle pulse when row 0, plane 0 is latched

Behaviour:
- All outputs registered. Reset (async) and IDLE values: output_enable_n=1, row_select_n=all 1s, latch_enable=0, shift_start=0, swap_ack=0, frame_start=0, shift_row=0, shift_plane=0. Internal next-pair pointer = (0,0). Reset mid-frame drops straight to these values.
- States: IDLE, SHIFT_FIRST, BLANK, LATCH, DISPLAY, WAIT_SHIFT.
- IDLE: when enable=1, assert shift_start for the pointer pair the next cycle and go to SHIFT_FIRST. Latency from enable rise to shift_start is 1 cycle.
- SHIFT_FIRST: wait for shift_done, then go to BLANK.
- BLANK: output_enable_n=1 for BLANK_TICKS cycles, then go to LATCH.
- LATCH: latch_enable=1 for LATCH_TICKS cycles. row_select_n switches to the latched row on the first LATCH cycle. frame_start pulses on the first LATCH cycle when the latched pair is (0,0). Then go to DISPLAY.
- DISPLAY: output_enable_n=0 for exactly BASE_TICKS<<plane cycles.
  - On the first DISPLAY cycle, if enable=1, pulse shift_start for the next pair and clear the sticky done flag.
  - Pair order: plane increments first. After the last plane, row increments and plane returns to 0. After the last row, the pair wraps to (0,0).
- DISPLAY expiry:
  - sticky done set and enable=1 → BLANK.
  - shift outstanding → WAIT_SHIFT (output_enable_n=1).
  - enable=0 with no shift outstanding → IDLE.
- WAIT_SHIFT: on shift_done, go to BLANK if enable=1, else IDLE.
- Sticky done flag: set by shift_done, cleared by shift_start. A shift_done arriving in the same cycle as shift_start is ignored.
- Swap handshake: swap_ack pulses in the same cycle as shift_start for pair (0,0), and only if swap_req=1. This includes the first shift after IDLE. No ack at any other pair.
- Dwell counter width: clog2(BASE_TICKS<<(BIT_PLANES-1))+1. The counter reloads at each state entry; no wrap.
- On re-enable from IDLE, scanning restarts at the stored pointer pair, not (0,0).

Decomposition:
- Package cube_pkg: NUM_ROWS, BIT_PLANES, ROW_W/PLANE_W (clog2), the scan_state_t enum, and the dwell-width function.
- One sub-module: dwell_timer, a loadable down-counter with a done flag. It serves the BLANK, LATCH and DISPLAY counts.

Test Plan:
Common parameters for all scenarios: ROWS=2, PLANES=2, BASE=2, BLANK=1, LATCH=1; shifter model returns shift_done 3 cycles after shift_start.
1. Reset, then enable=1 → shift_start one cycle later with (0,0). Then 1 cycle OE_n=1, 1 cycle latch, row_select_n=2'b10, OE_n=0 for 2 cycles. Second shift requested with (0,1).
2. Steady scan → OE-low widths repeat 2, 4, 2, 4. row_select_n sequence is 10, 10, 01, 01. frame_start pulses every 4 latches.
3. Shifter model delay raised to 6 cycles → WAIT_SHIFT is entered. OE_n=1 until shift_done, and no latch pulse occurs before shift_done.
4. Hold swap_req=1 → swap_ack coincides only with shift_start at (0,0), exactly once per frame.
5. Drop enable during plane-1 DISPLAY → DISPLAY finishes, the outstanding shift completes, then IDLE with OE_n=1 and row_select_n=2'b11. Re-enable resumes at the stored pair.
6. Assert reset_n=0 mid-DISPLAY → outputs go to their reset values immediately, asynchronously, without waiting for a clock edge.
